// File: rtl/assembly_sequencer.sv
// Two-pass replay controller for the text assembler: streams the source buffer as
// line/character strobes and commits finished instruction words to instruction memory.
package assembly_sequencer_pkg;
  localparam logic [1:0] IDLE                = 2'd0;
  localparam logic [1:0] PC_MAPPING          = 2'd1;
  localparam logic [1:0] INSTRUCTION_MAPPING = 2'd2;
endpackage

module assembly_sequencer
  import assembly_sequencer_pkg::*;
#(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUMBER_LINES  = 256,
  parameter int MEM_LATENCY   = 2,
  parameter int CHAR_GAP      = 2,
  parameter int DONE_TIMEOUT  = 16
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic                                          start_in,
  input  logic [$clog2(NUMBER_LINES):0]                 num_lines_in,
  output logic [$clog2(NUMBER_LINES*CHAR_PER_LINE)-1:0] text_addr_out,
  input  logic [7:0]                                    text_data_in,
  output logic                                          new_line_out,
  output logic                                          new_character_out,
  output logic [7:0]                                    char_out,
  output logic [$clog2(NUMBER_LINES)-1:0]               line_count_out,
  output logic [$clog2(CHAR_PER_LINE)-1:0]              char_count_out,
  output logic [1:0]                                    assembler_state_out,
  input  logic                                          asm_done_in,
  input  logic                                          asm_error_in,
  input  logic [31:0]                                   instruction_in,
  output logic                                          imem_we_out,
  output logic [$clog2(NUMBER_LINES)-1:0]               imem_addr_out,
  output logic [31:0]                                   imem_data_out,
  output logic                                          busy_out,
  output logic                                          done_out,
  output logic                                          error_out,
  output logic [$clog2(NUMBER_LINES)-1:0]               error_line_out,
  output logic [2:0]                                    dbg_state_out
);
  localparam int LW      = $clog2(NUMBER_LINES);
  localparam int CW      = $clog2(CHAR_PER_LINE);
  localparam int AW      = $clog2(NUMBER_LINES*CHAR_PER_LINE);
  localparam int MAX_A   = (MEM_LATENCY > CHAR_GAP) ? MEM_LATENCY : CHAR_GAP;
  localparam int CNT_MAX = (MAX_A > DONE_TIMEOUT) ? MAX_A : DONE_TIMEOUT;
  localparam int TW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEWLINE, S_FETCH, S_EMIT, S_GAP, S_LINE_END, S_NEXT_LINE, S_FINISH
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [TW-1:0]   r_cnt;
  logic            r_pass;        // 0 = label pass, 1 = instruction pass
  logic [LW:0]     r_num_lines;
  logic [LW-1:0]   r_line;
  logic [CW-1:0]   r_char;
  logic [7:0]      r_char_out;
  logic [LW-1:0]   r_idx;
  logic            r_idx_full;
  logic            r_we;
  logic [LW-1:0]   r_imem_addr;
  logic [31:0]     r_imem_data;
  logic            r_error;
  logic [LW-1:0]   r_error_line;
  logic            w_busy;
  logic            w_eol;
  logic            w_last_line;
  logic            w_commit;
  logic            w_overflow;
  logic            w_err_event;
  logic [LW:0]     w_num_clamped;

  assign w_busy        = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign w_eol         = (r_char_out == 8'h0A) || (r_char_out == 8'h00) ||
                         (r_char == CW'(CHAR_PER_LINE - 1));
  assign w_last_line   = (({1'b0, r_line} + (LW+1)'(1)) == r_num_lines);
  assign w_num_clamped = (num_lines_in > (LW+1)'(NUMBER_LINES)) ? (LW+1)'(NUMBER_LINES)
                                                                 : num_lines_in;
  assign w_err_event   = (w_busy && asm_error_in) || w_overflow;

  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    w_overflow   = 1'b0;
    case (r_state)
      S_IDLE:      if (start_in) w_state_next = (num_lines_in == '0) ? S_FINISH : S_NEWLINE;
      S_NEWLINE:   w_state_next = S_FETCH;
      S_FETCH:     if (r_cnt == TW'(MEM_LATENCY)) w_state_next = S_EMIT;
      S_EMIT: begin
        if (CHAR_GAP == 0) w_state_next = w_eol ? S_LINE_END : S_FETCH;
        else               w_state_next = S_GAP;
      end
      S_GAP:       if (r_cnt == TW'(CHAR_GAP - 1)) w_state_next = w_eol ? S_LINE_END : S_FETCH;
      S_LINE_END: begin
        if (!r_pass) begin
          w_state_next = S_NEXT_LINE;
        end else if (asm_done_in) begin
          w_state_next = S_NEXT_LINE;
          w_commit     = !r_idx_full;
          w_overflow   = r_idx_full;
        end else if (r_cnt == TW'(DONE_TIMEOUT - 1)) begin
          w_state_next = S_NEXT_LINE;
        end
      end
      S_NEXT_LINE: w_state_next = (w_last_line && r_pass) ? S_FINISH : S_NEWLINE;
      S_FINISH:    w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
    // An assembler error preempts everything, including a same-cycle commit.
    if (w_busy && asm_error_in) begin
      w_state_next = S_FINISH;
      w_commit     = 1'b0;
      w_overflow   = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt        <= '0;
      r_pass       <= 1'b0;
      r_num_lines  <= '0;
      r_line       <= '0;
      r_char       <= '0;
      r_char_out   <= '0;
      r_idx        <= '0;
      r_idx_full   <= 1'b0;
      r_we         <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_data  <= '0;
      r_error      <= 1'b0;
      r_error_line <= '0;
    end else begin
      r_we  <= w_commit;
      r_cnt <= (w_state_next != r_state) ? '0 : r_cnt + TW'(1);
      if (w_err_event && !r_error) begin
        r_error      <= 1'b1;
        r_error_line <= r_line;
      end
      case (r_state)
        S_IDLE: if (start_in) begin
          r_num_lines  <= w_num_clamped;
          r_error      <= 1'b0;
          r_error_line <= '0;
          r_idx        <= '0;
          r_idx_full   <= 1'b0;
          r_pass       <= 1'b0;
          r_line       <= '0;
          r_char       <= '0;
        end
        S_NEWLINE: r_char <= '0;
        S_FETCH:   if (r_cnt == TW'(MEM_LATENCY)) r_char_out <= text_data_in;
        S_EMIT, S_GAP: if (w_state_next == S_FETCH) r_char <= r_char + CW'(1);
        S_LINE_END: if (w_commit) begin
          r_imem_addr <= r_idx;
          r_imem_data <= instruction_in;
          if (r_idx == LW'(NUMBER_LINES - 1)) r_idx_full <= 1'b1;
          else                                r_idx      <= r_idx + LW'(1);
        end
        S_NEXT_LINE: if (w_state_next == S_NEWLINE) begin
          if (w_last_line) begin
            r_pass <= 1'b1;
            r_line <= '0;
          end else begin
            r_line <= r_line + LW'(1);
          end
        end
        S_FINISH: r_pass <= 1'b0;
        default: ;
      endcase
    end
  end

  assign text_addr_out       = AW'(r_line) * AW'(CHAR_PER_LINE) + AW'(r_char);
  assign new_line_out        = (r_state == S_NEWLINE);
  assign new_character_out   = (r_state == S_EMIT);
  assign char_out            = r_char_out;
  assign line_count_out      = r_line;
  assign char_count_out      = r_char;
  assign assembler_state_out = !w_busy ? IDLE : (r_pass ? INSTRUCTION_MAPPING : PC_MAPPING);
  assign imem_we_out         = r_we;
  assign imem_addr_out       = r_imem_addr;
  assign imem_data_out       = r_imem_data;
  assign busy_out            = w_busy;
  assign done_out            = (r_state == S_FINISH);
  assign error_out           = r_error;
  assign error_line_out      = r_error_line;
  assign dbg_state_out       = r_state;
endmodule

// File: tb/tb_assembly_sequencer.sv
// Scoreboard bench for assembly_sequencer: text memory and assembler mocks drive the DUT,
// expected strobes and writes are queued up front and a negedge monitor pops and compares.
module tb_assembly_sequencer;
  import assembly_sequencer_pkg::*;

  localparam int CPL = 64;
  localparam int NL  = 256;
  localparam int ML  = 2;
  localparam int CH_SPACING = 6;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        start_in = 1'b0;
  logic [8:0]  num_lines_in = '0;
  logic [13:0] text_addr_out;
  logic [7:0]  text_data_in;
  logic        new_line_out, new_character_out;
  logic [7:0]  char_out;
  logic [7:0]  line_count_out;
  logic [5:0]  char_count_out;
  logic [1:0]  assembler_state_out;
  logic        asm_done_in = 1'b0;
  logic        asm_error_in = 1'b0;
  logic [31:0] instruction_in = '0;
  logic        imem_we_out;
  logic [7:0]  imem_addr_out;
  logic [31:0] imem_data_out;
  logic        busy_out, done_out, error_out;
  logic [7:0]  error_line_out;
  logic [2:0]  dbg_state_out;

  assembly_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .num_lines_in(num_lines_in),
    .text_addr_out(text_addr_out), .text_data_in(text_data_in),
    .new_line_out(new_line_out), .new_character_out(new_character_out),
    .char_out(char_out), .line_count_out(line_count_out), .char_count_out(char_count_out),
    .assembler_state_out(assembler_state_out), .asm_done_in(asm_done_in),
    .asm_error_in(asm_error_in), .instruction_in(instruction_in),
    .imem_we_out(imem_we_out), .imem_addr_out(imem_addr_out), .imem_data_out(imem_data_out),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
    .error_line_out(error_line_out), .dbg_state_out(dbg_state_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- text memory model ----------------
  logic [7:0] text_mem [0:NL*CPL-1];
  logic [7:0] rd_pipe  [0:ML-1];
  always @(posedge clk_in) begin
    rd_pipe[0] <= text_mem[text_addr_out];
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign text_data_in = rd_pipe[ML-1];

  logic        resp_valid [0:NL-1];
  logic [31:0] resp_word  [0:NL-1];
  int          err_line = -1;
  int          err_cyc = 0;

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_ch_q[$];
  logic [9:0]  exp_nl_q[$];
  logic [39:0] exp_wr_q[$];
  int checks = 0, errors = 0;
  int nl_cnt, ch_cnt, wr_cnt, done_cnt, busy_cnt;
  int last_ch_cyc, last_lf_cyc, last_done_cyc;
  int nl_gap [0:1][0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_text();
    for (int i = 0; i < NL*CPL; i++) text_mem[i] = 8'h00;
    for (int i = 0; i < NL; i++) begin
      resp_valid[i] = 1'b0;
      resp_word[i]  = '0;
    end
    err_line = -1;
  endtask

  task automatic load_line(input int ln, input string s);
    for (int i = 0; i < s.len(); i++) text_mem[ln*CPL + i] = s[i];
  endtask

  task automatic reset_counts();
    exp_ch_q.delete(); exp_nl_q.delete(); exp_wr_q.delete();
    nl_cnt = 0; ch_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
    last_ch_cyc = 0; last_lf_cyc = 0; last_done_cyc = 0;
    for (int p = 0; p < 2; p++) for (int l = 0; l < 16; l++) nl_gap[p][l] = 0;
  endtask

  // Walks the loaded text the way the sequencer should, queueing every expected strobe.
  task automatic build_expect(input int nlines);
    int idx = 0;
    bit stop = 0;
    logic [7:0] b;
    for (int p = 0; p < 2 && !stop; p++) begin
      for (int l = 0; l < nlines && !stop; l++) begin
        exp_nl_q.push_back({2'(p + 1), 8'(l)});
        if (p == 1 && l == err_line) begin
          stop = 1;
        end else begin
          for (int c = 0; c < CPL; c++) begin
            b = text_mem[l*CPL + c];
            exp_ch_q.push_back({2'(p + 1), 8'(l), 6'(c), b});
            if (b == 8'h0A || b == 8'h00) break;
          end
          if (p == 1 && resp_valid[l]) begin
            exp_wr_q.push_back({8'(idx), resp_word[l]});
            idx++;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic start_run(input int n);
    @(negedge clk_in);
    num_lines_in = 9'(n);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("done_seen", 64'(done_cnt != start_cnt), 64'd1);
    repeat (4) @(negedge clk_in);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_ch_left"}, 64'(exp_ch_q.size()), 64'd0);
    check({tag, "_nl_left"}, 64'(exp_nl_q.size()), 64'd0);
    check({tag, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grp_a"}, 64'({text_addr_out, new_line_out, new_character_out, char_out,
                                line_count_out, char_count_out, assembler_state_out,
                                imem_we_out, imem_addr_out}), 64'd0);
    check({tag, "_grp_b"}, 64'({imem_data_out, busy_out, done_out, error_out,
                                error_line_out}), 64'd0);
  endtask

  // ---------------- assembler mock ----------------
  initial begin
    logic [7:0] ln;
    forever begin
      @(negedge clk_in);
      if (!rst_in && new_line_out && assembler_state_out == INSTRUCTION_MAPPING &&
          int'(line_count_out) == err_line) begin
        asm_error_in = 1'b1;
        err_cyc = cyc;
        @(negedge clk_in);
        asm_error_in = 1'b0;
      end else if (!rst_in && new_character_out && char_out == 8'h0A &&
                   assembler_state_out == INSTRUCTION_MAPPING && resp_valid[line_count_out]) begin
        ln = line_count_out;
        repeat (5) @(negedge clk_in);
        if (!rst_in) begin
          instruction_in = resp_word[ln];
          asm_done_in = 1'b1;
        end
        @(negedge clk_in);
        asm_done_in = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (busy_out) busy_cnt++;
      if (new_line_out) begin
        nl_cnt++;
        if (exp_nl_q.size() == 0) check("nl_unexpected", 64'd1, 64'd0);
        else check("nl_event", 64'({assembler_state_out, line_count_out}), 64'(exp_nl_q.pop_front()));
        if (assembler_state_out == PC_MAPPING || assembler_state_out == INSTRUCTION_MAPPING)
          nl_gap[assembler_state_out - 2'd1][line_count_out[3:0]] = cyc - last_lf_cyc;
      end
      if (new_character_out) begin
        ch_cnt++;
        if (exp_ch_q.size() == 0) check("ch_unexpected", 64'd1, 64'd0);
        else check("ch_event", 64'({assembler_state_out, line_count_out, char_count_out, char_out}),
                   64'(exp_ch_q.pop_front()));
        if (char_count_out != 6'd0) check("ch_spacing", 64'(cyc - last_ch_cyc), 64'(CH_SPACING));
        last_ch_cyc = cyc;
        if (char_out == 8'h0A) last_lf_cyc = cyc;
      end
      if (imem_we_out) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else check("wr_event", 64'({imem_addr_out, imem_data_out}), 64'(exp_wr_q.pop_front()));
      end
      if (done_out) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("busy_low_at_done", 64'(busy_out), 64'd0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    clear_text();
    reset_counts();
    rst_in = 1'b1;
    #3;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Two instructions, both answered by the mock assembler.
    clear_text(); reset_counts();
    load_line(0, "addi x1, x0, 5\n");
    load_line(1, "add x2, x1, x1\n");
    resp_valid[0] = 1'b1; resp_word[0] = 32'h0050_0093;
    resp_valid[1] = 1'b1; resp_word[1] = 32'h0010_8133;
    build_expect(2);
    start_run(2);
    wait_done(3000);
    check("t1_new_lines", 64'(nl_cnt), 64'd4);
    check("t1_chars", 64'(ch_cnt), 64'd60);
    check("t1_writes", 64'(wr_cnt), 64'd2);
    check("t1_done_pulses", 64'(done_cnt), 64'd1);
    check("t1_error", 64'(error_out), 64'd0);
    check("t1_gap_pass1", 64'(nl_gap[0][1]), 64'd5);
    check("t1_gap_done", 64'(nl_gap[1][1]), 64'd7);
    check_drained("t1");

    // Zero lines: straight to finish.
    clear_text(); reset_counts();
    start_run(0);
    wait_done(20);
    check("t2_new_lines", 64'(nl_cnt), 64'd0);
    check("t2_chars", 64'(ch_cnt), 64'd0);
    check("t2_done_pulses", 64'(done_cnt), 64'd1);
    check("t2_busy_cycles", 64'(busy_cnt), 64'd0);

    // Full-width line with no terminator.
    clear_text(); reset_counts();
    for (int i = 0; i < CPL; i++) text_mem[i] = 8'h41 + 8'(i % 26);
    build_expect(1);
    start_run(1);
    wait_done(3000);
    check("t3_chars", 64'(ch_cnt), 64'd128);
    check("t3_new_lines", 64'(nl_cnt), 64'd2);
    check("t3_writes", 64'(wr_cnt), 64'd0);
    check_drained("t3");

    // Label-only line times out without a write.
    clear_text(); reset_counts();
    load_line(0, "addi x1, x0, 5\n");
    load_line(1, "loop:\n");
    load_line(2, "add x2, x1, x1\n");
    resp_valid[0] = 1'b1; resp_word[0] = 32'h0050_0093;
    resp_valid[2] = 1'b1; resp_word[2] = 32'h0010_8133;
    build_expect(3);
    start_run(3);
    wait_done(3000);
    check("t4_writes", 64'(wr_cnt), 64'd2);
    check("t4_chars", 64'(ch_cnt), 64'd72);
    check("t4_new_lines", 64'(nl_cnt), 64'd6);
    check("t4_gap_timeout", 64'(nl_gap[1][2]), 64'd20);
    check_drained("t4");

    // Error on line 3 of pass 2.
    clear_text(); reset_counts();
    for (int l = 0; l < 5; l++) begin
      load_line(l, "addi x1, x0, 5\n");
      resp_valid[l] = 1'b1;
      resp_word[l] = 32'h0000_1000 + 32'(l);
    end
    err_line = 3;
    build_expect(5);
    start_run(5);
    wait_done(5000);
    check("t5_error", 64'(error_out), 64'd1);
    check("t5_error_line", 64'(error_line_out), 64'd3);
    check("t5_done_latency", 64'(last_done_cyc - err_cyc), 64'd1);
    check("t5_writes", 64'(wr_cnt), 64'd3);
    check("t5_new_lines", 64'(nl_cnt), 64'd9);
    check_drained("t5");
    err_line = -1;
    reset_counts();
    build_expect(1);
    start_run(1);
    check("t5_error_cleared", 64'(error_out), 64'd0);
    wait_done(3000);
    check_drained("t5b");

    // Asynchronous reset in the middle of pass 2, then a clean restart.
    clear_text(); reset_counts();
    load_line(0, "addi x1, x0, 5\n");
    load_line(1, "add x2, x1, x1\n");
    resp_valid[0] = 1'b1; resp_word[0] = 32'h0050_0093;
    resp_valid[1] = 1'b1; resp_word[1] = 32'h0010_8133;
    build_expect(2);
    start_run(2);
    n = 0;
    while (!(new_character_out && assembler_state_out == INSTRUCTION_MAPPING &&
             char_count_out == 6'd3) && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check("t6_reached_pass2", 64'(n < 3000), 64'd1);
    #2 rst_in = 1'b1;
    #1 check_idle_outputs("t6_async_reset");
    @(negedge clk_in);
    reset_counts();
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);
    check("t6_no_writes_after_reset", 64'(wr_cnt), 64'd0);
    reset_counts();
    build_expect(2);
    start_run(2);
    wait_done(3000);
    check("t6_restart_writes", 64'(wr_cnt), 64'd2);
    check_drained("t6");

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
